// File: rtl/ir_packet_sequencer.sv
// Sequences one IR car-control packet (start, car-select, four command bits, each followed
// by a gap) by restarting the carrier generator per segment and counting its period strobes.
module ir_packet_sequencer #(
    parameter int START_BURST    = 88,
    parameter int CAR_BURST      = 22,
    parameter int GAP            = 40,
    parameter int ASSERT_BURST   = 44,
    parameter int DEASSERT_BURST = 22,
    parameter int CNT_WIDTH      = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SEND,
    input  logic [3:0] COMMAND,
    input  logic       Pulse_Strobe,
    output logic       pack_gen_EN,
    output logic       pack_strobe,
    output logic       IR_GATE,
    output logic       BUSY,
    output logic       DONE
);

    // Zero-length segments would never end, so they are stretched to one period.
    localparam logic [CNT_WIDTH:0] L_START = (CNT_WIDTH+1)'((START_BURST    == 0) ? 1 : START_BURST);
    localparam logic [CNT_WIDTH:0] L_CAR   = (CNT_WIDTH+1)'((CAR_BURST      == 0) ? 1 : CAR_BURST);
    localparam logic [CNT_WIDTH:0] L_GAP   = (CNT_WIDTH+1)'((GAP            == 0) ? 1 : GAP);
    localparam logic [CNT_WIDTH:0] L_ONE   = (CNT_WIDTH+1)'((ASSERT_BURST   == 0) ? 1 : ASSERT_BURST);
    localparam logic [CNT_WIDTH:0] L_ZERO  = (CNT_WIDTH+1)'((DEASSERT_BURST == 0) ? 1 : DEASSERT_BURST);

    typedef enum logic [2:0] {S_IDLE, S_START, S_GAP, S_CARSEL, S_CMD} state_t;

    state_t               state_q, state_d;
    logic [2:0]           seg_q, seg_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [3:0]           cmd_q;
    logic                 strobe_q, echo_q, en_q, gate_q, done_q;

    logic [CNT_WIDTH:0]   seg_len, cnt_inc;
    logic [1:0]           bit_idx;
    logic                 tick, seg_end, adv;

    // seg_q records the last burst finished: 0 = start, 1 = car-select, 2..5 = bit0..bit3.
    always_comb begin
        bit_idx = 2'(seg_q - 3'd1);
        case (state_q)
            S_START:  seg_len = L_START;
            S_CARSEL: seg_len = L_CAR;
            S_CMD:    seg_len = cmd_q[bit_idx] ? L_ONE : L_ZERO;
            default:  seg_len = L_GAP;
        endcase
        tick    = Pulse_Strobe && !echo_q && (state_q != S_IDLE);
        cnt_inc = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);
        seg_end = tick && (cnt_inc >= seg_len);

        state_d = state_q;
        seg_d   = seg_q;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: if (SEND) begin
                state_d = S_START;
                seg_d   = 3'd0;
                adv     = 1'b1;
            end
            S_START: if (seg_end) begin
                state_d = S_GAP;
                seg_d   = 3'd0;
                adv     = 1'b1;
            end
            S_CARSEL: if (seg_end) begin
                state_d = S_GAP;
                seg_d   = 3'd1;
                adv     = 1'b1;
            end
            S_CMD: if (seg_end) begin
                state_d = S_GAP;
                seg_d   = seg_q + 3'd1;
                adv     = 1'b1;
            end
            S_GAP: if (seg_end) begin
                adv = 1'b1;
                if (seg_q == 3'd0)      state_d = S_CARSEL;
                else if (seg_q == 3'd5) state_d = S_IDLE;
                else                    state_d = S_CMD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            seg_q    <= '0;
            cnt_q    <= '0;
            cmd_q    <= '0;
            strobe_q <= 1'b0;
            echo_q   <= 1'b0;
            en_q     <= 1'b0;
            gate_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            if (state_q == S_IDLE && SEND) cmd_q <= COMMAND;
            if (adv)       cnt_q <= '0;
            else if (tick) cnt_q <= cnt_q + CNT_WIDTH'(1);
            strobe_q <= adv && (state_d != S_IDLE);
            echo_q   <= strobe_q;
            en_q     <= (state_d != S_IDLE);
            gate_q   <= (state_d == S_START) || (state_d == S_CARSEL) || (state_d == S_CMD);
            done_q   <= adv && (state_d == S_IDLE);
        end
    end

    assign pack_gen_EN = en_q;
    assign BUSY        = en_q;
    assign pack_strobe = strobe_q;
    assign IR_GATE     = gate_q;
    assign DONE        = done_q;

endmodule

// File: tb/tb_ir_packet_sequencer.sv
// Scoreboard bench: stimulus queues the expected burst/gap list per packet, a monitor
// measures each segment in carrier periods and compares as segments close.
module tb_ir_packet_sequencer;
    logic       CLK = 1'b0, RST = 1'b1, SEND = 1'b0, Pulse_Strobe = 1'b0;
    logic [3:0] COMMAND = 4'd0;
    logic       pack_gen_EN, pack_strobe, IR_GATE, BUSY, DONE;

    ir_packet_sequencer #(
        .START_BURST(4), .CAR_BURST(2), .GAP(3),
        .ASSERT_BURST(2), .DEASSERT_BURST(1), .CNT_WIDTH(8)
    ) dut (
        .CLK(CLK), .RST(RST), .SEND(SEND), .COMMAND(COMMAND), .Pulse_Strobe(Pulse_Strobe),
        .pack_gen_EN(pack_gen_EN), .pack_strobe(pack_strobe), .IR_GATE(IR_GATE),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {bit gate; int len; bit last;} seg_t;
    seg_t exp_q[$];
    int   n_tests = 0, n_fail = 0, done_cnt = 0, exp_done = 0;
    bit   gen_rand = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_seg(input bit g, input int l, input bit last);
        seg_t s;
        s.gate = g; s.len = l; s.last = last;
        exp_q.push_back(s);
    endfunction

    // Reference packet: burst/gap lengths straight from the packet layout.
    function automatic void push_packet(input logic [3:0] c);
        push_seg(1, 4, 0); push_seg(0, 3, 0);
        push_seg(1, 2, 0); push_seg(0, 3, 0);
        for (int i = 0; i < 4; i++) begin
            push_seg(1, c[i] ? 2 : 1, 0);
            push_seg(0, 3, i == 3);
        end
        exp_done++;
    endfunction

    // Carrier generator model: echo one cycle after a restart, then one strobe per period.
    int gen_pc = 0, gen_per = 10;
    bit gen_pend = 0;
    always @(posedge CLK) begin
        #1;
        if (pack_gen_EN && gen_pend) begin
            Pulse_Strobe = 1'b1;
            gen_pc = 0; gen_pend = 0;
            gen_per = gen_rand ? int'($urandom_range(3, 12)) : 10;
        end else if (pack_gen_EN) begin
            gen_pc++;
            if (gen_pc >= gen_per) begin Pulse_Strobe = 1'b1; gen_pc = 0; end
            else Pulse_Strobe = 1'b0;
        end else begin
            Pulse_Strobe = ($urandom_range(0, 3) == 0);
            gen_pc = 0; gen_pend = 0;
        end
        if (pack_strobe) gen_pend = 1;
    end

    // Monitor: a segment runs from one pack_strobe to the next pack_strobe or DONE.
    int cyc = 0, seg_cnt = 0, last_cyc = 0;
    bit open = 0, seg_gate = 0, echo_m = 0;

    task automatic close_seg(input bit want_last);
        seg_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_segment", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("seg_len", seg_cnt, e.len);
        chk("seg_gate", seg_gate, e.gate);
        chk("seg_order", want_last, e.last);
        chk("seg_end_timing", last_cyc, cyc - 1);
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            exp_q.delete();
            open = 0; echo_m = 0;
        end else begin
            if (DONE) begin
                done_cnt++;
                chk("done_with_open_seg", open, 1);
                chk("done_busy_en", {BUSY, pack_gen_EN}, 0);
                if (open) close_seg(1);
                open = 0;
            end
            if (pack_strobe) begin
                if (open) close_seg(0);
                open = 1; seg_cnt = 0; seg_gate = IR_GATE;
                chk("entry_busy_en", {BUSY, pack_gen_EN}, 3);
                if (Pulse_Strobe && !echo_m) begin seg_cnt++; last_cyc = cyc; end
            end else if (open) begin
                if (Pulse_Strobe && !echo_m) begin seg_cnt++; last_cyc = cyc; end
                chk("gate_steady", IR_GATE, seg_gate);
            end else if (!DONE) begin
                chk("idle_outputs", {BUSY, pack_gen_EN, IR_GATE}, 0);
            end
            echo_m = pack_strobe;
        end
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic send(input logic [3:0] c, input bit accepted);
        SEND = 1'b1; COMMAND = c;
        if (accepted) push_packet(c);
        step();
        SEND = 1'b0; COMMAND = 4'($urandom);
    endtask

    task automatic wait_ps(input int n);
        int seen = 0;
        for (int i = 0; i < 3000 && seen < n; i++) begin
            step();
            if (pack_strobe) seen++;
        end
        chk("wait_strobe_timeout", seen, n);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (DONE) begin ok = 1; break; end
        end
        chk("done_timeout", ok, 1);
    endtask

    initial begin
        int d0;
        RST = 1'b1;
        repeat (3) step();
        chk("reset_outputs", {pack_gen_EN, pack_strobe, IR_GATE, BUSY, DONE}, 0);
        RST = 1'b0;
        repeat (2) step();

        // Basic packet with a SEND while busy that must be ignored.
        send(4'b1010, 1);
        chk("start_strobe", pack_strobe, 1);
        wait_ps(3);
        send(4'b1111, 0);
        wait_done();
        step();
        chk("busy_after_done", BUSY, 0);
        repeat (3) step();

        // Asynchronous reset in the middle of the car-select burst.
        send(4'($urandom), 1);
        wait_ps(2);
        repeat (5) step();
        chk("in_carsel_gate", IR_GATE, 1);
        d0 = done_cnt;
        #2 RST = 1'b1;
        #1 chk("rst_async_outputs", {pack_gen_EN, pack_strobe, IR_GATE, BUSY, DONE}, 0);
        exp_done--;
        @(posedge CLK); #3 RST = 1'b0;
        repeat (4) step();
        chk("no_done_on_reset", done_cnt, d0);

        // Fresh packet, then a back-to-back SEND in the DONE cycle.
        send(4'b0101, 1);
        wait_done();
        send(4'($urandom), 1);
        chk("b2b_strobe", pack_strobe, 1);
        chk("b2b_busy", BUSY, 1);
        wait_done();

        // Randomized packets, periods, idle spacing and busy SENDs.
        gen_rand = 1'b1;
        for (int p = 0; p < 10; p++) begin
            repeat ($urandom_range(0, 4)) step();
            send(4'($urandom), 1);
            if ($urandom_range(0, 1) == 1) begin
                wait_ps($urandom_range(1, 10));
                send(4'($urandom), 0);
            end
            wait_done();
        end

        repeat (5) step();
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, exp_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ir_packet_sequencer.md
Name: ir_packet_sequencer

Overview:
- Sequences one IR car-control packet by driving the carrier pulse generator (pack_gen_EN, pack_strobe) and counting its per-period Pulse_Strobe output.
- Also drives IR_GATE, which is high during bursts and low during gaps. IR_LED is formed externally as Pulse AND IR_GATE.
- Sits between the command source (a bus-mapped register or switches plus a send timer) and the pulse generator.

Parameters:
- START_BURST, 88, carrier periods in start burst
- CAR_BURST, 22, carrier periods in car-select burst
- GAP, 40, carrier periods in every gap
- ASSERT_BURST, 44, carrier periods for a command bit = 1
- DEASSERT_BURST, 22, carrier periods for a command bit = 0
- CNT_WIDTH, 8, segment counter width (must hold the largest burst or gap value)

Ports:
- CLK, input, 1, system clock
- RST, input, 1, asynchronous active-high reset
- SEND, input, 1, one-cycle request to transmit a packet
- COMMAND, input, 4, [0]=Right [1]=Left [2]=Backward [3]=Forward; sampled on an accepted SEND
- Pulse_Strobe, input, 1, one-cycle strobe per full carrier period, from the pulse generator
- pack_gen_EN, output, 1, pulse generator enable
- pack_strobe, output, 1, pulse generator restart, one cycle at each segment start
- IR_GATE, output, 1, high during burst segments
- BUSY, output, 1, packet in progress
- DONE, output, 1, one-cycle pulse when a packet completes

Behaviour:
- Reset: async; all outputs 0, state IDLE, counters 0, latched command 0. RST asserted mid-packet aborts immediately, with no DONE. First packet after release needs a new SEND.
- States: IDLE, START, GAP, CARSEL, CMD. A 3-bit segment index tracks the position after START: gap/carsel, then bit0..bit3 and their gaps.
- Packet order:
  - START(START_BURST), GAP
  - CARSEL(CAR_BURST), GAP
  - 4 × [CMD bit i (ASSERT_BURST if COMMAND[i] else DEASSERT_BURST), GAP], for i = 0..3
  - back to IDLE
- IDLE:
  - Outputs pack_gen_EN=0, IR_GATE=0, BUSY=0.
  - On SEND=1: latch COMMAND and go to START.
- SEND while BUSY=1 is ignored and not queued. COMMAND changes during a packet have no effect.
- All outputs are registered.
- In every non-IDLE state: pack_gen_EN=1 and BUSY=1. IR_GATE=1 in START, CARSEL and CMD; IR_GATE=0 in GAP.
- Segment entry: the first cycle in a new segment has pack_strobe=1, and the segment counter clears to 0.
- Echo suppression: the generator answers a restart with a Pulse_Strobe one cycle later. Pulse_Strobe in the cycle after pack_strobe=1 is ignored.
- Counting: every other Pulse_Strobe=1 increments the counter.
- Segment end: when the increment would reach the segment length L, that cycle is the segment's last. The next cycle is the next segment's entry, so there is no idle cycle between segments.
- Packet end: the last cycle of the final GAP moves to IDLE. DONE=1 on the first IDLE cycle, exactly one cycle; BUSY=0 and pack_gen_EN=0 in that same cycle.
- Carrier period: about 2×(pulse generator half-period) cycles, not fixed by this block. This block is purely event-counted.
- Length 0: any length parameter of 0 is treated as 1.
- SEND in the DONE cycle: accepted (state is IDLE).
- Pulse_Strobe in IDLE is ignored.
- Counter wrap: cannot occur with CNT_WIDTH ≥ clog2(max length + 1).

Test Plan:
- Common setup: parameters START_BURST=4, CAR_BURST=2, GAP=3, ASSERT_BURST=2, DEASSERT_BURST=1. Pulse generator model strobes every 10 cycles after a restart, plus the echo.
- Basic packet: RST then SEND with COMMAND=4'b1010 → IR_GATE segment lengths in periods are 4,(3),2,(3),1,(3),2,(3),1,(3),2,(3). There are 12 pack_strobe pulses; DONE is 1 for one cycle, then BUSY=0.
- Echo rejection: check that the Pulse_Strobe one cycle after each pack_strobe is not counted. START must last exactly 4 model periods, not 3.
- Busy rejection: a second SEND, with COMMAND=4'b1111, mid-packet → no restart. The transmitted bits still follow 4'b1010, and only one DONE occurs.
- Reset mid-operation: assert RST asynchronously in the CARSEL segment, between clock edges → all outputs 0 immediately, no DONE. A fresh SEND then yields a complete packet.
- Back-to-back: SEND in the DONE cycle → the next packet's START pack_strobe appears on the following cycle, and BUSY is low for exactly 1 cycle.
